// File: rtl/lsu_pkg.sv
// Shared types and the request legality check for the load/store controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RESP
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // A request is rejected for an illegal size code, a misaligned half/word,
    // or a word index that falls outside the attached memory.
    function automatic logic req_is_bad(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [31:0] mem_words);
        logic bad;
        bad = 1'b0;
        if (size == 2'b11)
            bad = 1'b1;
        if ((size == SZ_HALF) && addr[0])
            bad = 1'b1;
        if ((size == SZ_WORD) && (addr[1:0] != 2'b00))
            bad = 1'b1;
        if ({2'b00, addr[31:2]} >= mem_words)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  byte_off,
    input  logic        is_unsigned,
    input  logic [31:0] ld_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_result,
    output logic [31:0] st_merged
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  lane_sel;

    assign ld_byte = ld_word[{byte_off, 3'b000} +: 8];
    assign ld_half = ld_word[{byte_off[1], 4'b0000} +: 16];

    // Pick the addressed lane and sign- or zero-extend it.
    always_comb begin
        ld_result = ld_word;
        case (size)
            SZ_BYTE: ld_result = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_result = {{16{~is_unsigned & ld_half[15]}}, ld_half};
            default: ld_result = ld_word;
        endcase
    end

    // Byte lanes overwritten by the store; the rest keep the old word.
    always_comb begin
        lane_sel = 4'b1111;
        case (size)
            SZ_BYTE: lane_sel = 4'b0001 << byte_off;
            SZ_HALF: lane_sel = byte_off[1] ? 4'b1100 : 4'b0011;
            default: lane_sel = 4'b1111;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] src;
            // Right-aligned store data is replicated onto the lane it targets.
            assign src = (size == SZ_BYTE) ? st_data[7:0] :
                         (size == SZ_HALF) ? st_data[8*(gi%2) +: 8] :
                                             st_data[8*gi +: 8];
            assign st_merged[8*gi +: 8] = lane_sel[gi] ? src : ld_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: request latch, access FSM and response registers.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 32,
    localparam int AW        = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_ld_data
);

    lsu_state_e  state_reg, state_next;
    lsu_req_t    req_in;
    logic        req_bad;

    logic        we_reg;
    size_e       size_reg;
    logic        uns_reg;
    logic [AW-1:0] word_idx_reg;
    logic [1:0]  byte_off_reg;
    logic [31:0] wdata_reg;
    logic [31:0] merged_reg;
    logic [31:0] rsp_rdata_reg;
    logic        rsp_err_reg;

    logic [31:0] ld_result;
    logic [31:0] st_merged;

    assign req_in  = '{we: req_we, size: req_size, uns: req_unsigned,
                       addr: req_addr, wdata: req_wdata};
    assign req_bad = req_is_bad(req_in.size, req_in.addr, 32'(MEM_SIZE));

    lsu_align u_align (
        .size        (size_reg),
        .byte_off    (byte_off_reg),
        .is_unsigned (uns_reg),
        .ld_word     (mem_ld_data),
        .st_data     (wdata_reg),
        .ld_result   (ld_result),
        .st_merged   (st_merged)
    );

    // State register; reset drops the enables immediately via the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next state and all memory/handshake outputs.
    always_comb begin
        state_next  = state_reg;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)
                        state_next = RESP;
                    else if (!req_in.we)
                        state_next = RD;
                    else if (req_in.size == SZ_WORD)
                        state_next = WR;
                    else
                        state_next = RMW_RD;
                end
            end
            RD: begin
                mem_rd_en  = 1'b1;
                mem_addr   = word_idx_reg;
                state_next = RESP;
            end
            RMW_RD: begin
                mem_rd_en  = 1'b1;
                mem_addr   = word_idx_reg;
                state_next = WR;
            end
            WR: begin
                mem_wr_en   = 1'b1;
                mem_addr    = word_idx_reg;
                mem_wr_data = (size_reg == SZ_WORD) ? wdata_reg : merged_reg;
                state_next  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, RMW merge capture and held response values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_reg        <= 1'b0;
            size_reg      <= SZ_BYTE;
            uns_reg       <= 1'b0;
            word_idx_reg  <= '0;
            byte_off_reg  <= 2'b00;
            wdata_reg     <= '0;
            merged_reg    <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg        <= req_in.we;
                        size_reg      <= size_e'(req_in.size);
                        uns_reg       <= req_in.uns;
                        word_idx_reg  <= req_in.addr[AW+1:2];
                        byte_off_reg  <= req_in.addr[1:0];
                        wdata_reg     <= req_in.wdata;
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= req_bad;
                    end
                end
                RD:      rsp_rdata_reg <= ld_result;
                RMW_RD:  merged_reg    <= st_merged;
                RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl with an attached word memory and a
// behavioural byte-level reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_ld_data;

    logic [31:0] dmem    [32];
    logic [31:0] ref_mem [32];

    int n_vec  = 0;
    int n_miss = 0;
    int n_txn  = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.DATA_WIDTH(32), .MEM_SIZE(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .mem_ld_data  (mem_ld_data)
    );

    assign mem_ld_data = dmem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en)
            dmem[mem_addr] <= mem_wr_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction, entered and left at a falling edge with the DUT idle.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        logic [31:0] idx, w, v, mask, hold_rdata;
        logic        exp_err, hold_err, addr_ok;
        int          sh, exp_lat, exp_rd, exp_wr, cyc, rd_seen, wr_seen;

        // Reference model: byte-addressed memory semantics.
        idx     = addr >> 2;
        exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                  (size == 2'd2 && addr[1:0] != 2'd0) || (idx >= 32);
        v = 32'h0;
        if (exp_err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
            w = ref_mem[idx[4:0]];
            if (size == 2'd0) begin
                sh = 8 * int'(addr[1:0]);
                v  = (w >> sh) & 32'hFF;
                if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end else if (size == 2'd1) begin
                sh = 16 * int'(addr[1]);
                v  = (w >> sh) & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end else begin
                v = w;
            end
        end else if (size == 2'd2) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
            ref_mem[idx[4:0]] = wdata;
        end else begin
            exp_lat = 3; exp_rd = 1; exp_wr = 1;
            if (size == 2'd0) begin
                sh   = 8 * int'(addr[1:0]);
                mask = 32'hFF << sh;
                ref_mem[idx[4:0]] = (ref_mem[idx[4:0]] & ~mask) | ((wdata & 32'hFF) << sh);
            end else begin
                sh   = 16 * int'(addr[1]);
                mask = 32'hFFFF << sh;
                ref_mem[idx[4:0]] = (ref_mem[idx[4:0]] & ~mask) | ((wdata & 32'hFFFF) << sh);
            end
        end

        check_eq("req_ready_idle", {31'b0, req_ready}, 32'h1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        rsp_ready    = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        // The request is latched; scramble the bus to show it is ignored now.
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;

        cyc = 1; rd_seen = 0; wr_seen = 0; addr_ok = 1'b1;
        while (!rsp_valid && cyc < 10) begin
            if (mem_rd_en) rd_seen++;
            if (mem_wr_en) wr_seen++;
            if ((mem_rd_en || mem_wr_en) && mem_addr != idx[4:0]) addr_ok = 1'b0;
            if (req_ready) addr_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check_eq("latency", 32'(cyc), 32'(exp_lat));
        check_eq("rd_en_cycles", 32'(rd_seen), 32'(exp_rd));
        check_eq("wr_en_cycles", 32'(wr_seen), 32'(exp_wr));
        check_eq("busy_addr", {31'b0, addr_ok}, 32'h1);
        check_eq("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        check_eq("rsp_rdata", rsp_rdata, v);
        if (we && !exp_err)
            check_eq("mem_word", dmem[idx[4:0]], ref_mem[idx[4:0]]);

        hold_rdata = rsp_rdata;
        hold_err   = rsp_err;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check_eq("bp_valid", {31'b0, rsp_valid}, 32'h1);
            check_eq("bp_req_ready", {31'b0, req_ready}, 32'h0);
            check_eq("bp_rdata", rsp_rdata, hold_rdata);
            check_eq("bp_err", {31'b0, rsp_err}, {31'b0, hold_err});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("idle_after", {30'b0, rsp_valid, req_ready}, 32'h1);
        check_eq("idle_mem_out", {mem_wr_data[26:0], mem_addr}, 32'h0);

        $display("txn %0d we=%0d size=%0d uns=%0d addr=%h wdata=%h stall=%0d -> rdata=%h err=%0d lat=%0d",
                 n_txn, we, size, uns, addr, wdata, stall, hold_rdata, hold_err, cyc);
        n_txn++;
    endtask

    // Byte store aborted by reset while reading the old word.
    task automatic reset_mid_rmw();
        logic [31:0] old_word;
        old_word     = dmem[4];
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h11;
        req_wdata    = 32'h0000_00A5;
        rsp_ready    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("rst_rmw_rd_active", {31'b0, mem_rd_en}, 32'h1);
        reset = 1'b0;
        #1;
        check_eq("rst_enables", {30'b0, mem_rd_en, mem_wr_en}, 32'h0);
        check_eq("rst_handshake", {30'b0, req_ready, rsp_valid}, 32'h2);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        check_eq("rst_mem_out", {mem_wr_data[26:0], mem_addr}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_eq("rst_no_write", dmem[4], old_word);
        check_eq("rst_no_rsp", {31'b0, rsp_valid}, 32'h0);
        $display("txn %0d reset during RMW_RD of byte store @00000011", n_txn);
        n_txn++;
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r_size;
        logic [31:0] r_addr;
        int          sel;

        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dmem[i]    = $urandom;
            ref_mem[i] = dmem[i];
        end
        repeat (2) @(negedge clk);
        check_eq("reset_handshake", {30'b0, req_ready, rsp_valid}, 32'h2);
        check_eq("reset_rsp", {rsp_rdata[30:0], rsp_err}, 32'h0);
        check_eq("reset_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("reset_enables", {30'b0, mem_rd_en, mem_wr_en}, 32'h0);
        check_eq("reset_mem_out", {mem_wr_data[26:0], mem_addr}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Word store / load round trip
        run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
        check_eq("word_store_value", dmem[4], 32'hDEAD_BEEF);
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        // Sub-word read-modify-write
        run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0055, 0);
        check_eq("rmw_value", dmem[4], 32'hDEAD_55EF);
        run_req(1'b1, 2'd1, 1'b0, 32'h16, 32'h1234_ABCD, 0);
        // Extension cases
        run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_0000, 0);
        run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
        run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
        run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
        run_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0);
        // Errors
        run_req(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 0);
        run_req(1'b1, 2'd2, 1'b0, 32'h6, 32'h1111_1111, 0);
        run_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 0);
        run_req(1'b1, 2'd2, 1'b0, 32'h80, 32'h2222_2222, 0);
        run_req(1'b0, 2'd2, 1'b0, 32'h7C, 32'h0, 0);
        // Backpressure
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
        run_req(1'b0, 2'd1, 1'b0, 32'h1, 32'h0, 3);
        // Reset mid-operation
        reset_mid_rmw();

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            sel    = int'($urandom_range(0, 9));
            r_size = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 19) == 0)
                r_addr = $urandom;
            else
                r_addr = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 9) < 7) begin
                if (r_size == 2'd1) r_addr[0]   = 1'b0;
                if (r_size == 2'd2) r_addr[1:0] = 2'b00;
            end
            run_req(1'($urandom), r_size, 1'($urandom), r_addr, $urandom,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
        end

        for (int i = 0; i < 32; i++)
            check_eq("final_mem", dmem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
